// File: rtl/blank_router.sv
// Walks the blank tile (value 0) of an N x N sliding-puzzle board to a target cell.
// Unlocked cells only; every move goes out on a valid/ready stream before it is applied.
module blank_router #(
    parameter int unsigned N         = 4,
    parameter int unsigned TW        = 4,
    parameter int unsigned MAX_STEPS = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [N*N*TW-1:0]            i_board,
    input  logic [N*N-1:0]               i_mask,
    input  logic [$clog2(N)-1:0]         i_tgt_row,
    input  logic [$clog2(N)-1:0]         i_tgt_col,
    output logic [N*N*TW-1:0]            o_board,
    output logic                         o_busy,
    output logic                         o_move_valid,
    input  logic                         i_move_ready,
    output logic [1:0]                   o_move_dir,
    output logic [$clog2(MAX_STEPS+1)-1:0] o_steps,
    output logic                         o_done,
    output logic                         o_fail
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned SW = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirDown  = 2'd1;
    localparam logic [1:0] DirLeft  = 2'd2;
    localparam logic [1:0] DirRight = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StLoad, StCheck, StPlan, StEmit, StDone, StFail
    } state_t;

    state_t            state_q;
    logic [N*N*TW-1:0] board_q;
    logic [N*N-1:0]    mask_q;
    logic [CW-1:0]     tgt_row_q, tgt_col_q;
    logic [CW-1:0]     blank_row_q, blank_col_q;
    logic [CW-1:0]     last_row_q, last_col_q;
    logic              last_valid_q;
    logic [SW-1:0]     steps_q;
    logic [1:0]        dir_q;
    logic              busy_q, valid_q, done_q, fail_q;

    // Lowest-index zero cell of the working board.
    logic          zero_found;
    logic [CW-1:0] zero_row, zero_col;

    always_comb begin
        zero_found = 1'b0;
        zero_row   = '0;
        zero_col   = '0;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (!zero_found && board_q[(r * int'(N) + c) * int'(TW) +: TW] == '0) begin
                    zero_found = 1'b1;
                    zero_row   = CW'(r);
                    zero_col   = CW'(c);
                end
            end
        end
    end

    logic tgt_bad;

    always_comb begin
        tgt_bad = 1'b0;
        if (int'(tgt_row_q) >= int'(N) || int'(tgt_col_q) >= int'(N)) begin
            tgt_bad = 1'b1;
        end else begin
            tgt_bad = mask_q[int'(tgt_row_q) * int'(N) + int'(tgt_col_q)];
        end
    end

    // Neighbour coordinates per direction, indexed by the direction code.
    logic [CW-1:0] nb_row [4];
    logic [CW-1:0] nb_col [4];
    logic [3:0]    legal;
    logic [3:0]    is_last;

    always_comb begin
        nb_row[DirUp]    = blank_row_q - 1'b1;
        nb_col[DirUp]    = blank_col_q;
        nb_row[DirDown]  = blank_row_q + 1'b1;
        nb_col[DirDown]  = blank_col_q;
        nb_row[DirLeft]  = blank_row_q;
        nb_col[DirLeft]  = blank_col_q - 1'b1;
        nb_row[DirRight] = blank_row_q;
        nb_col[DirRight] = blank_col_q + 1'b1;

        legal          = '0;
        legal[DirUp]    = blank_row_q != '0;
        legal[DirDown]  = int'(blank_row_q) < int'(N) - 1;
        legal[DirLeft]  = blank_col_q != '0;
        legal[DirRight] = int'(blank_col_q) < int'(N) - 1;

        is_last = '0;
        for (int d = 0; d < 4; d++) begin
            if (legal[d] && mask_q[int'(nb_row[d]) * int'(N) + int'(nb_col[d])]) begin
                legal[d] = 1'b0;
            end
            is_last[d] = last_valid_q && nb_row[d] == last_row_q && nb_col[d] == last_col_q;
        end
    end

    // Candidate order: vertical toward target, horizontal toward target, then U, D, L, R.
    logic [1:0] cand_dir [6];
    logic [5:0] cand_en;
    logic       plan_ok;
    logic [1:0] plan_dir;

    always_comb begin
        cand_dir[0] = (tgt_row_q < blank_row_q) ? DirUp : DirDown;
        cand_en[0]  = tgt_row_q != blank_row_q;
        cand_dir[1] = (tgt_col_q < blank_col_q) ? DirLeft : DirRight;
        cand_en[1]  = tgt_col_q != blank_col_q;
        cand_dir[2] = DirUp;
        cand_dir[3] = DirDown;
        cand_dir[4] = DirLeft;
        cand_dir[5] = DirRight;
        cand_en[5:2] = 4'b1111;

        plan_ok  = 1'b0;
        plan_dir = DirUp;
        for (int i = 0; i < 6; i++) begin
            if (!plan_ok && cand_en[i] && legal[cand_dir[i]] && !is_last[cand_dir[i]]) begin
                plan_ok  = 1'b1;
                plan_dir = cand_dir[i];
            end
        end
        // Dead end: step back where we came from.
        for (int d = 0; d < 4; d++) begin
            if (!plan_ok && legal[d] && is_last[d]) begin
                plan_ok  = 1'b1;
                plan_dir = 2'(d);
            end
        end
    end

    logic [CW-1:0] mv_row, mv_col;
    int            mv_base;
    int            blank_base;

    always_comb begin
        mv_row     = nb_row[dir_q];
        mv_col     = nb_col[dir_q];
        mv_base    = (int'(mv_row) * int'(N) + int'(mv_col)) * int'(TW);
        blank_base = (int'(blank_row_q) * int'(N) + int'(blank_col_q)) * int'(TW);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            board_q      <= '0;
            mask_q       <= '0;
            tgt_row_q    <= '0;
            tgt_col_q    <= '0;
            blank_row_q  <= '0;
            blank_col_q  <= '0;
            last_row_q   <= '0;
            last_col_q   <= '0;
            last_valid_q <= 1'b0;
            steps_q      <= '0;
            dir_q        <= DirUp;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        board_q      <= i_board;
                        mask_q       <= i_mask;
                        tgt_row_q    <= i_tgt_row;
                        tgt_col_q    <= i_tgt_col;
                        steps_q      <= '0;
                        last_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    if (i_abort || !zero_found || tgt_bad) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else begin
                        blank_row_q <= zero_row;
                        blank_col_q <= zero_col;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (i_abort) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else if (blank_row_q == tgt_row_q && blank_col_q == tgt_col_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (steps_q == SW'(MAX_STEPS)) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else begin
                        state_q <= StPlan;
                    end
                end
                StPlan: begin
                    if (i_abort || !plan_ok) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else begin
                        dir_q   <= plan_dir;
                        valid_q <= 1'b1;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    // Abort outranks a simultaneous handshake: the move is never applied.
                    if (i_abort) begin
                        valid_q <= 1'b0;
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else if (i_move_ready) begin
                        board_q[blank_base +: TW] <= board_q[mv_base +: TW];
                        board_q[mv_base +: TW]    <= '0;
                        last_row_q   <= blank_row_q;
                        last_col_q   <= blank_col_q;
                        last_valid_q <= 1'b1;
                        blank_row_q  <= mv_row;
                        blank_col_q  <= mv_col;
                        steps_q      <= steps_q + 1'b1;
                        valid_q      <= 1'b0;
                        state_q      <= StCheck;
                    end
                end
                StDone, StFail: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_board      = board_q;
    assign o_busy       = busy_q;
    assign o_move_valid = valid_q;
    assign o_move_dir   = dir_q;
    assign o_steps      = steps_q;
    assign o_done       = done_q;
    assign o_fail       = fail_q;

endmodule

// File: tb/tb_blank_router.sv
// Directed bench for blank_router: N=4, TW=4; a second instance runs with a two-move budget.
module tb_blank_router;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start2;
    logic        abort;
    logic        ready;
    logic [63:0] board;
    logic [15:0] mask;
    logic [1:0]  tgt_row;
    logic [1:0]  tgt_col;

    logic [63:0] ob;
    logic        busy, mv, done, fail;
    logic [1:0]  md;
    logic [6:0]  steps;

    logic [63:0] ob2;
    logic        busy2, mv2, done2, fail2;
    logic [1:0]  md2;
    logic [1:0]  steps2;

    int checks = 0;
    int errors = 0;

    // Boards: cell i at bits [4i+:4], so the leftmost hex digit is cell 15.
    localparam logic [63:0] B1     = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] B2     = 64'h0EDC_BA98_7654_321F;
    localparam logic [63:0] B2_U1  = 64'hBEDC_0A98_7654_321F;
    localparam logic [63:0] B2_U2  = 64'hBEDC_7A98_0654_321F;
    localparam logic [63:0] B2_FIN = 64'hBEDC_7A98_6504_321F;
    localparam logic [63:0] B3     = 64'hFED0_BA98_7654_321C;
    localparam logic [63:0] B3_FIN = 64'hBFED_7A98_6540_321C;

    blank_router #(.N(4), .TW(4), .MAX_STEPS(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_board(board), .i_mask(mask), .i_tgt_row(tgt_row), .i_tgt_col(tgt_col),
        .o_board(ob), .o_busy(busy), .o_move_valid(mv), .i_move_ready(ready),
        .o_move_dir(md), .o_steps(steps), .o_done(done), .o_fail(fail)
    );

    blank_router #(.N(4), .TW(4), .MAX_STEPS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_abort(abort),
        .i_board(board), .i_mask(mask), .i_tgt_row(tgt_row), .i_tgt_col(tgt_col),
        .o_board(ob2), .o_busy(busy2), .o_move_valid(mv2), .i_move_ready(ready),
        .o_move_dir(md2), .o_steps(steps2), .o_done(done2), .o_fail(fail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [63:0] b, input logic [15:0] m,
                             input logic [1:0] r, input logic [1:0] c);
        board   = b;
        mask    = m;
        tgt_row = r;
        tgt_col = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Follows a run with ready high: dirs holds move k at [2k+:2].
    task automatic expect_moves(input string tag, input logic [15:0] dirs, input int n,
                                input int exp_steps, input logic [63:0] fin);
        bit         seen;
        int         waits;
        logic [1:0] want;
        for (int k = 0; k < n; k++) begin
            seen  = 1'b0;
            waits = 0;
            for (int w = 0; w < 8 && !seen; w++) begin
                if (mv) seen = 1'b1;
                else begin
                    tick();
                    waits++;
                end
            end
            check($sformatf("%s move%0d valid", tag, k), 64'(seen), 64'd1);
            if (k > 0) check($sformatf("%s move%0d cadence", tag, k), 64'(waits), 64'd2);
            want = dirs[2*k +: 2];
            check($sformatf("%s move%0d dir", tag, k), 64'(md), 64'(want));
            tick();
        end
        seen  = 1'b0;
        waits = 0;
        for (int w = 0; w < 8 && !seen; w++) begin
            if (done) seen = 1'b1;
            else begin
                tick();
                waits++;
            end
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " done latency"}, 64'(waits), 64'd1);
        check({tag, " steps"}, 64'(steps), 64'(exp_steps));
        check({tag, " board"}, ob, fin);
        tick();
        check({tag, " idle after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; ready = 1'b0;
        board = '0; mask = '0; tgt_row = '0; tgt_col = '0;
        tick();
        tick();
        check("reset board", ob, 64'd0);
        check("reset steps", 64'(steps), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(mv), 64'd0);
        check("reset dir", 64'(md), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset fail", 64'(fail), 64'd0);
        rst = 1'b0;
        tick();

        // Target already reached.
        start_run(B1, 16'h0000, 2'd0, 2'd0);
        check("s1 busy in load", 64'(busy), 64'd1);
        tick();
        check("s1 no early done", 64'(done), 64'd0);
        tick();
        check("s1 done at T0+3", 64'(done), 64'd1);
        check("s1 no move", 64'(mv), 64'd0);
        check("s1 steps", 64'(steps), 64'd0);
        tick();
        check("s1 done pulse", 64'(done), 64'd0);
        check("s1 idle", 64'(busy), 64'd0);
        check("s1 board", ob, B1);

        // Blank (3,3) to (1,1) with ready tied high.
        ready = 1'b1;
        start_run(B2, 16'h0000, 2'd1, 2'd1);
        tick();
        tick();
        check("s2 no valid in plan", 64'(mv), 64'd0);
        tick();
        check("s2 first valid T0+4", 64'(mv), 64'd1);
        expect_moves("s2", 16'h00A0, 4, 4, B2_FIN);
        tick();
        tick();
        check("s2 board held in idle", ob, B2_FIN);
        check("s2 steps held in idle", 64'(steps), 64'd4);

        // Path around a locked row segment.
        start_run(B3, 16'h0700, 2'd1, 2'd0);
        expect_moves("s3", 16'hA83F, 8, 8, B3_FIN);

        // Back-pressure on the first offer.
        ready = 1'b0;
        start_run(B2, 16'h0000, 2'd1, 2'd1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s4 stall%0d valid", i), 64'(mv), 64'd1);
            check($sformatf("s4 stall%0d dir", i), 64'(md), 64'd0);
            check($sformatf("s4 stall%0d board", i), ob, B2);
            check($sformatf("s4 stall%0d steps", i), 64'(steps), 64'd0);
            if (i < 4) tick();
        end
        ready = 1'b1;
        tick();
        check("s4 first move applied", ob, B2_U1);
        check("s4 first step", 64'(steps), 64'd1);
        expect_moves("s4", 16'h0028, 3, 4, B2_FIN);

        // Two-move budget runs out before the target.
        board = B2; mask = 16'h0000; tgt_row = 2'd1; tgt_col = 2'd1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                if (mv2) seen = 1'b1;
                else tick();
            end
            check($sformatf("s5 move%0d valid", k), 64'(seen), 64'd1);
            check($sformatf("s5 move%0d dir", k), 64'(md2), 64'd0);
            tick();
        end
        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            if (fail2) seen = 1'b1;
            else tick();
        end
        check("s5 fail seen", 64'(seen), 64'd1);
        check("s5 no done", 64'(done2), 64'd0);
        check("s5 busy in fail", 64'(busy2), 64'd1);
        check("s5 steps", 64'(steps2), 64'd2);
        check("s5 board", ob2, B2_U2);
        tick();

        // Masked target is rejected in LOAD.
        start_run(B2, 16'h0020, 2'd1, 2'd1);
        tick();
        check("s6 fail", 64'(fail), 64'd1);
        check("s6 no move", 64'(mv), 64'd0);
        check("s6 steps", 64'(steps), 64'd0);
        check("s6 busy in fail", 64'(busy), 64'd1);
        tick();
        check("s6 fail pulse", 64'(fail), 64'd0);
        check("s6 idle", 64'(busy), 64'd0);

        // Abort coinciding with ready in EMIT.
        ready = 1'b1;
        start_run(B2, 16'h0000, 2'd1, 2'd1);
        tick();
        tick();
        tick();
        check("s7 offer", 64'(mv), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s7 fail", 64'(fail), 64'd1);
        check("s7 board unchanged", ob, B2);
        check("s7 steps unchanged", 64'(steps), 64'd0);
        check("s7 valid dropped", 64'(mv), 64'd0);
        tick();
        check("s7 idle", 64'(busy), 64'd0);

        // Reset while a move is on offer.
        ready = 1'b0;
        start_run(B3, 16'h0700, 2'd1, 2'd0);
        tick();
        tick();
        tick();
        check("s8 offer", 64'(mv), 64'd1);
        check("s8 dir right", 64'(md), 64'd3);
        rst = 1'b1;
        tick();
        check("s8 board", ob, 64'd0);
        check("s8 steps", 64'(steps), 64'd0);
        check("s8 busy", 64'(busy), 64'd0);
        check("s8 valid", 64'(mv), 64'd0);
        check("s8 dir", 64'(md), 64'd0);
        check("s8 done", 64'(done), 64'd0);
        check("s8 fail", 64'(fail), 64'd0);
        rst = 1'b0;
        tick();
        check("s8 quiet done", 64'(done), 64'd0);
        check("s8 quiet fail", 64'(fail), 64'd0);
        check("s8 stays idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
